wb_corrector_csr_mc: RTL and testbench
======================================

Name: wb_corrector_csr_mc

Overview:
Parametrised multi-channel successor of the white balance corrector CSR block.
- AXI4-Lite slave holding mode, calibration strobe, manual lock and CH_CNT manual coefficients of COEF_W bits each.
- Coefficient writes go to shadow registers. A commit request applies them atomically on the next frame start (sof_i), so the datapath never sees a torn coefficient set.
- Sits between the AXI4-Lite interconnect and the wb corrector datapath. Decode errors return SLVERR.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of the register map
CH_CNT, 3, number of colour channels (1..8)
COEF_W, 16, coefficient width in bits (1..32)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
awaddr_i/awvalid_i/awready_o  in/in/out  32/1/1  AXI4-Lite write address
wdata_i/wstrb_i/wvalid_i/wready_o  in/in/in/out  32/4/1/1  AXI4-Lite write data
bresp_o/bvalid_o/bready_i  out/out/in  2/1/1  AXI4-Lite write response
araddr_i/arvalid_i/arready_o  in/in/out  32/1/1  AXI4-Lite read address
rdata_o/rresp_o/rvalid_o/rready_i  out/out/out/in  32/2/1/1  AXI4-Lite read data
sof_i  in  1  one-cycle frame-start pulse from the video datapath
cur_coef_i  in  CH_CNT*COEF_W  live coefficients from the datapath, channel 0 in the LSBs
mode_o  out  2  correction mode
cal_stb_o  out  1  one-cycle calibration pulse
man_lock_o  out  1  manual lock
man_coef_o  out  CH_CNT*COEF_W  active manual coefficients, channel 0 in the LSBs

Behaviour:
- Word offsets from BASE_ADDR:
  - 0 MODE_CR [1:0], RW, reset 2
  - 1 CAL_STB_CR, write-only, read 0
  - 2 MAN_LOCK_CR [0], RW, reset 0
  - 3 COMMIT_CR, write-only, read 0
  - 4 STATUS_SR [0]=commit_pending, RO
  - 5..4+CH_CNT MAN_COEF_CR[i] [COEF_W-1:0], RW shadow, reset 0
  - 5+CH_CNT..4+2*CH_CNT CUR_COEF_SR[i], RO, returns cur_coef_i slice zero-extended
- Address bits [1:0] are ignored.
- Error responses (resp 2'b10, no state change):
  - any address outside the map;
  - a write to STATUS_SR or CUR_COEF_SR;
  - a read of an unmapped address (rdata 0).
- All other transactions return OKAY (2'b00).
- Write channel:
  - AW and W are accepted independently. awready_o drops after the AW handshake and wready_o drops after the W handshake, until B completes.
  - Only one write is outstanding at a time.
  - Register update happens in the cycle after both halves are captured. bvalid_o rises in the same cycle and holds until bready_i.
  - wstrb_i is applied per byte, only to implemented bits. Writes to control bits (MODE, LOCK, CAL_STB, COMMIT) need wstrb[0].
- Read channel:
  - arready_o = !rvalid_o && !ar_pending.
  - rvalid_o rises 1 cycle after the AR handshake. rdata_o/rresp_o are held stable until rready_i.
  - rdata_o returns to 0 after the R handshake.
- CAL_STB_CR: a write with wdata[0]=1 produces cal_stb_o=1 for exactly one cycle, in the cycle after the register update. Back-to-back writes produce separate pulses.
- Commit:
  - A write of 1 to COMMIT_CR sets commit_pending.
  - On the first sof_i while pending: man_coef_o <= all shadows, and commit_pending clears.
  - A commit write in the same cycle as sof_i applies at the NEXT sof_i.
  - Shadow writes while pending are allowed; the shadow values present at sof_i are the ones applied.
  - sof_i with no pending commit: no change.
  - Repeated commit writes while pending: no effect beyond pending staying at 1.
- man_lock_o=1 blocks application: commit_pending stays 1 and sof_i is ignored until the lock is cleared.
- Reset values: mode_o=2, all other outputs 0, commit_pending=0, all ready outputs 1 from the cycle after reset.
- Reset mid-transaction aborts it: valids drop and captured halves are discarded.

Optional Feature:
WB_CSR_COMMIT_IRQ_EN:
- Defined:
  - adds output irq_o (1 bit);
  - irq_o pulses for one cycle in the cycle after the shadows are applied;
  - adds IRQ_EN_CR at word offset 5+2*CH_CNT, bit0 RW, reset 0, which gates the pulse.
- Undefined: no irq_o port and no IRQ_EN_CR; that offset decodes as SLVERR.

Test Plan:
1. Reset, then read offsets 0, 2 and 4 -> rdata 2, 0, 0, all OKAY; after reset man_coef_o=0 and mode_o=2.
2. Write MAN_COEF_CR[1]=16'h1234 (CH_CNT=3, COEF_W=16), then COMMIT_CR=1 -> STATUS_SR reads 1 and man_coef_o is unchanged; pulse sof_i -> man_coef_o[31:16]=16'h1234 and STATUS_SR reads 0.
3. Send W 3 cycles before AW for MODE_CR=1 -> wready_o low after the W handshake; bvalid_o one cycle after AW; mode_o=1; bresp 0.
4. Read offset 0x40 and write CUR_COEF_SR[0] -> both return resp 2'b10; no register changes.
5. Set MAN_LOCK_CR=1, commit, pulse sof_i twice -> man_coef_o held; clear the lock, pulse sof_i -> shadows applied.
6. Write CAL_STB_CR=1 twice back-to-back -> two distinct single-cycle cal_stb_o pulses.

Source files
------------

// File: rtl/wb_corrector_csr_mc.sv
// Multi-channel AXI4-Lite CSR for the white balance corrector with frame-synchronous coefficient commit.
// Defining WB_CSR_COMMIT_IRQ_EN adds irq_o and the IRQ_EN_CR register.
module wb_corrector_csr_mc #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CH_CNT    = 3,
  parameter int unsigned COEF_W    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              awaddr_i,
  input  logic                     awvalid_i,
  output logic                     awready_o,
  input  logic [31:0]              wdata_i,
  input  logic [3:0]               wstrb_i,
  input  logic                     wvalid_i,
  output logic                     wready_o,
  output logic [1:0]               bresp_o,
  output logic                     bvalid_o,
  input  logic                     bready_i,
  input  logic [31:0]              araddr_i,
  input  logic                     arvalid_i,
  output logic                     arready_o,
  output logic [31:0]              rdata_o,
  output logic [1:0]               rresp_o,
  output logic                     rvalid_o,
  input  logic                     rready_i,
  input  logic                     sof_i,
  input  logic [CH_CNT*COEF_W-1:0] cur_coef_i,
  output logic [1:0]               mode_o,
  output logic                     cal_stb_o,
  output logic                     man_lock_o,
`ifdef WB_CSR_COMMIT_IRQ_EN
  output logic                     irq_o,
`endif
  output logic [CH_CNT*COEF_W-1:0] man_coef_o
);

  localparam int unsigned WIDX_W      = 30;
  localparam int unsigned OFF_MODE    = 0;
  localparam int unsigned OFF_CAL     = 1;
  localparam int unsigned OFF_LOCK    = 2;
  localparam int unsigned OFF_COMMIT  = 3;
  localparam int unsigned OFF_STATUS  = 4;
  localparam int unsigned OFF_COEF0   = 5;
  localparam int unsigned OFF_CUR0    = 5 + CH_CNT;
`ifdef WB_CSR_COMMIT_IRQ_EN
  localparam int unsigned OFF_IRQ_EN  = 5 + 2 * CH_CNT;
  localparam int unsigned NUM_REGS    = 6 + 2 * CH_CNT;
`else
  localparam int unsigned NUM_REGS    = 5 + 2 * CH_CNT;
`endif
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  MODE_RST    = 2'd2;

  typedef logic [CH_CNT-1:0][COEF_W-1:0] coef_set_t;

  function automatic logic [WIDX_W-1:0] word_idx(input logic [WIDX_W-1:0] wa);
    return wa - BASE_ADDR[31:2];
  endfunction

  function automatic logic in_map(input logic [WIDX_W-1:0] wa);
    logic [WIDX_W-1:0] rel;
    rel = wa - BASE_ADDR[31:2];
    return (wa >= BASE_ADDR[31:2]) && (rel < WIDX_W'(NUM_REGS));
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int unsigned b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  // Write channel and register state
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              aw_pend_q, aw_pend_d;
  logic              w_pend_q, w_pend_d;
  logic [WIDX_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [1:0]        mode_q, mode_d;
  logic              cal_stb_q, cal_stb_d;
  logic              man_lock_q, man_lock_d;
  logic              commit_pend_q, commit_pend_d;
  coef_set_t         shadow_q, shadow_d;
  coef_set_t         man_coef_q, man_coef_d;
`ifdef WB_CSR_COMMIT_IRQ_EN
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
`endif

  // Read channel state
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [WIDX_W-1:0] wr_addr, wr_idx, rd_idx;
  logic [31:0]       wr_data, wr_mask;
  logic [3:0]        wr_strb;
  logic              wr_go, wr_ok, apply;
  logic [31:0]       rd_data_c;
  logic              rd_ok_c;
  logic              unused_addr_bits;

  assign aw_hs   = awvalid_i && awready_q;
  assign w_hs    = wvalid_i && wready_q;
  assign b_hs    = bvalid_q && bready_i;
  assign ar_hs   = arvalid_i && arready_q;
  assign r_hs    = rvalid_q && rready_i;

  assign wr_addr = aw_pend_q ? awaddr_q : awaddr_i[31:2];
  assign wr_data = w_pend_q ? wdata_q : wdata_i;
  assign wr_strb = w_pend_q ? wstrb_q : wstrb_i;
  assign wr_mask = strb_mask(wr_strb);
  assign wr_idx  = word_idx(wr_addr);
  assign wr_go   = (aw_pend_q || aw_hs) && (w_pend_q || w_hs);
  assign wr_ok   = in_map(wr_addr) && (wr_idx != WIDX_W'(OFF_STATUS)) &&
                   !((wr_idx >= WIDX_W'(OFF_CUR0)) && (wr_idx < WIDX_W'(OFF_CUR0 + CH_CNT)));
  assign apply   = sof_i && commit_pend_q && !man_lock_q;

  assign unused_addr_bits = ^{awaddr_i[1:0], araddr_i[1:0]};

  // Write handshake, register updates and frame-synchronous commit
  always_comb begin
    awready_d     = awready_q;
    wready_d      = wready_q;
    aw_pend_d     = aw_pend_q;
    w_pend_d      = w_pend_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    mode_d        = mode_q;
    cal_stb_d     = 1'b0;
    man_lock_d    = man_lock_q;
    commit_pend_d = commit_pend_q;
    shadow_d      = shadow_q;
    man_coef_d    = man_coef_q;
`ifdef WB_CSR_COMMIT_IRQ_EN
    irq_en_d      = irq_en_q;
    irq_d         = 1'b0;
`endif

    if (aw_hs) begin
      aw_pend_d = 1'b1;
      awaddr_d  = awaddr_i[31:2];
      awready_d = 1'b0;
    end
    if (w_hs) begin
      w_pend_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
      wready_d = 1'b0;
    end

    // Apply uses the pre-write shadows; a commit write this cycle re-arms for the next frame
    if (apply) begin
      man_coef_d    = shadow_q;
      commit_pend_d = 1'b0;
`ifdef WB_CSR_COMMIT_IRQ_EN
      irq_d         = irq_en_q;
`endif
    end

    if (wr_go) begin
      aw_pend_d = 1'b0;
      w_pend_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (wr_ok) begin
        if (wr_strb[0]) begin
          if (wr_idx == WIDX_W'(OFF_MODE))   mode_d = wr_data[1:0];
          if (wr_idx == WIDX_W'(OFF_CAL))    cal_stb_d = wr_data[0];
          if (wr_idx == WIDX_W'(OFF_LOCK))   man_lock_d = wr_data[0];
          if ((wr_idx == WIDX_W'(OFF_COMMIT)) && wr_data[0]) commit_pend_d = 1'b1;
`ifdef WB_CSR_COMMIT_IRQ_EN
          if (wr_idx == WIDX_W'(OFF_IRQ_EN)) irq_en_d = wr_data[0];
`endif
        end
        for (int unsigned i = 0; i < CH_CNT; i++) begin
          if (wr_idx == WIDX_W'(OFF_COEF0 + i))
            shadow_d[i] = COEF_W'((32'(shadow_q[i]) & ~wr_mask) | (wr_data & wr_mask));
        end
      end
    end

    if (b_hs) begin
      bvalid_d  = 1'b0;
      bresp_d   = RESP_OKAY;
      awready_d = 1'b1;
      wready_d  = 1'b1;
    end
  end

  // Read data mux
  always_comb begin
    rd_data_c = '0;
    rd_idx    = word_idx(araddr_i[31:2]);
    rd_ok_c   = in_map(araddr_i[31:2]);
    if (rd_idx == WIDX_W'(OFF_MODE))   rd_data_c = 32'(mode_q);
    if (rd_idx == WIDX_W'(OFF_LOCK))   rd_data_c = 32'(man_lock_q);
    if (rd_idx == WIDX_W'(OFF_STATUS)) rd_data_c = 32'(commit_pend_q);
`ifdef WB_CSR_COMMIT_IRQ_EN
    if (rd_idx == WIDX_W'(OFF_IRQ_EN)) rd_data_c = 32'(irq_en_q);
`endif
    for (int unsigned i = 0; i < CH_CNT; i++) begin
      if (rd_idx == WIDX_W'(OFF_COEF0 + i)) rd_data_c = 32'(shadow_q[i]);
      if (rd_idx == WIDX_W'(OFF_CUR0 + i))  rd_data_c = 32'(cur_coef_i[i*COEF_W +: COEF_W]);
    end
    if (!rd_ok_c) rd_data_c = '0;
  end

  // Read handshake
  always_comb begin
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (r_hs) begin
      rvalid_d  = 1'b0;
      rdata_d   = '0;
      rresp_d   = RESP_OKAY;
      arready_d = 1'b1;
    end
    if (ar_hs) begin
      rvalid_d  = 1'b1;
      arready_d = 1'b0;
      rdata_d   = rd_data_c;
      rresp_d   = rd_ok_c ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      awready_q     <= 1'b1;
      wready_q      <= 1'b1;
      aw_pend_q     <= 1'b0;
      w_pend_q      <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
      mode_q        <= MODE_RST;
      cal_stb_q     <= 1'b0;
      man_lock_q    <= 1'b0;
      commit_pend_q <= 1'b0;
      shadow_q      <= '0;
      man_coef_q    <= '0;
      arready_q     <= 1'b1;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rresp_q       <= RESP_OKAY;
`ifdef WB_CSR_COMMIT_IRQ_EN
      irq_en_q      <= 1'b0;
      irq_q         <= 1'b0;
`endif
    end else begin
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      aw_pend_q     <= aw_pend_d;
      w_pend_q      <= w_pend_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      mode_q        <= mode_d;
      cal_stb_q     <= cal_stb_d;
      man_lock_q    <= man_lock_d;
      commit_pend_q <= commit_pend_d;
      shadow_q      <= shadow_d;
      man_coef_q    <= man_coef_d;
      arready_q     <= arready_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      rresp_q       <= rresp_d;
`ifdef WB_CSR_COMMIT_IRQ_EN
      irq_en_q      <= irq_en_d;
      irq_q         <= irq_d;
`endif
    end
  end

  assign awready_o  = awready_q;
  assign wready_o   = wready_q;
  assign bvalid_o   = bvalid_q;
  assign bresp_o    = bresp_q;
  assign arready_o  = arready_q;
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = rdata_q;
  assign rresp_o    = rresp_q;
  assign mode_o     = mode_q;
  assign cal_stb_o  = cal_stb_q;
  assign man_lock_o = man_lock_q;
  assign man_coef_o = man_coef_q;
`ifdef WB_CSR_COMMIT_IRQ_EN
  assign irq_o      = irq_q;
`endif

endmodule

// File: tb/tb_wb_corrector_csr_mc.sv
// Directed bench for wb_corrector_csr_mc (CH_CNT=3, COEF_W=16, BASE_ADDR=0).
module tb_wb_corrector_csr_mc;

  localparam int unsigned CH_CNT = 3;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned CW     = CH_CNT * COEF_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b1;
  logic [31:0]   araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b1;
  logic          sof = 1'b0;
  logic [CW-1:0] cur_coef = 48'hCCCC_BBBB_AAAA;
  logic [1:0]    mode;
  logic          cal_stb;
  logic          man_lock;
  logic [CW-1:0] man_coef;

  int checks = 0;
  int errors = 0;

  logic mon_en = 1'b0;
  logic cal_prev = 1'b0;
  int   cal_highs = 0;
  int   cal_rises = 0;

  wb_corrector_csr_mc #(
    .BASE_ADDR(32'h0000_0000),
    .CH_CNT   (CH_CNT),
    .COEF_W   (COEF_W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .awaddr_i  (awaddr),
    .awvalid_i (awvalid),
    .awready_o (awready),
    .wdata_i   (wdata),
    .wstrb_i   (wstrb),
    .wvalid_i  (wvalid),
    .wready_o  (wready),
    .bresp_o   (bresp),
    .bvalid_o  (bvalid),
    .bready_i  (bready),
    .araddr_i  (araddr),
    .arvalid_i (arvalid),
    .arready_o (arready),
    .rdata_o   (rdata),
    .rresp_o   (rresp),
    .rvalid_o  (rvalid),
    .rready_i  (rready),
    .sof_i     (sof),
    .cur_coef_i(cur_coef),
    .mode_o    (mode),
    .cal_stb_o (cal_stb),
    .man_lock_o(man_lock),
    .man_coef_o(man_coef)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mon_en) begin
      if (cal_stb) cal_highs++;
      if (cal_stb && !cal_prev) cal_rises++;
    end
    cal_prev = cal_stb;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    logic aw_ok, w_ok;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_ok = awvalid && awready;
      w_ok  = wvalid && wready;
      @(negedge clk);
      if (aw_ok) awvalid = 1'b0;
      if (w_ok)  wvalid = 1'b0;
      n++;
    end
    while (!bvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wr_bvalid", 64'(bvalid), 64'd1);
    resp = bresp;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    logic ok;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      ok = arready;
      @(negedge clk);
      if (ok) arvalid = 1'b0;
      n++;
    end
    while (!rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rd_rvalid", 64'(rvalid), 64'd1);
    d = rdata;
    resp = rresp;
    arvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic sof_pulse();
    @(negedge clk);
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    // 1: reset state and reset-value reads
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mode", 64'(mode), 64'd2);
    chk("rst_man_coef", 64'(man_coef), 64'd0);
    chk("rst_readies", 64'({awready, wready, arready}), 64'b111);
    chk("rst_valids", 64'({bvalid, rvalid, cal_stb, man_lock}), 64'd0);
    axi_read(32'h00, d, r); chk("rd_mode_data", 64'(d), 64'd2); chk("rd_mode_resp", 64'(r), 64'd0);
    chk("rdata_cleared", 64'({rvalid, rdata}), 64'd0);
    axi_read(32'h08, d, r); chk("rd_lock_data", 64'(d), 64'd0); chk("rd_lock_resp", 64'(r), 64'd0);
    axi_read(32'h10, d, r); chk("rd_status_data", 64'(d), 64'd0); chk("rd_status_resp", 64'(r), 64'd0);

    // 2: shadow write then commit at frame start
    axi_write(32'h18, 32'h0000_1234, 4'hF, r); chk("wr_coef1_resp", 64'(r), 64'd0);
    axi_write(32'h0C, 32'h1, 4'hF, r);         chk("wr_commit_resp", 64'(r), 64'd0);
    axi_read(32'h10, d, r); chk("status_pending", 64'(d), 64'd1);
    chk("coef_not_yet", 64'(man_coef), 64'd0);
    sof_pulse();
    chk("coef_applied", 64'(man_coef), 64'h0000_1234_0000);
    axi_read(32'h10, d, r); chk("status_cleared", 64'(d), 64'd0);
    axi_read(32'h18, d, r); chk("rd_shadow1", 64'(d), 64'h1234);

    // 3: W three cycles ahead of AW
    @(negedge clk);
    wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("wready_low_after_w", 64'(wready), 64'd0);
    chk("awready_still_high", 64'(awready), 64'd1);
    @(negedge clk);
    chk("no_bvalid_w_only", 64'(bvalid), 64'd0);
    @(negedge clk);
    awaddr = 32'h00; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("bvalid_after_aw", 64'(bvalid), 64'd1);
    chk("bresp_mode", 64'(bresp), 64'd0);
    chk("mode_written", 64'(mode), 64'd1);
    chk("readies_low_in_b", 64'({awready, wready}), 64'b00);
    @(negedge clk);
    chk("readies_restored", 64'({awready, wready, bvalid}), 64'b110);

    // 4: decode errors and strobe gating
    axi_read(32'h40, d, r); chk("rd_unmapped_resp", 64'(r), 64'd2); chk("rd_unmapped_data", 64'(d), 64'd0);
    axi_write(32'h20, 32'hFFFF, 4'hF, r); chk("wr_cur_resp", 64'(r), 64'd2);
    axi_write(32'h10, 32'h1, 4'hF, r);    chk("wr_status_resp", 64'(r), 64'd2);
    axi_write(32'h2C, 32'h1, 4'hF, r);    chk("wr_irqen_absent", 64'(r), 64'd2);
    axi_read(32'h10, d, r); chk("status_unchanged", 64'(d), 64'd0);
    axi_read(32'h28, d, r); chk("rd_cur2", 64'(d), 64'hCCCC); chk("rd_cur2_resp", 64'(r), 64'd0);
    axi_read(32'h04, d, r); chk("rd_cal_zero", 64'(d), 64'd0);
    axi_write(32'h00, 32'h3, 4'h0, r);    chk("wr_nostrb_resp", 64'(r), 64'd0);
    chk("mode_kept_nostrb", 64'(mode), 64'd1);
    axi_write(32'h03, 32'h3, 4'h1, r);
    chk("mode_lowbits_ignored", 64'(mode), 64'd3);
    chk("man_coef_after_errs", 64'(man_coef), 64'h0000_1234_0000);

    // 5: manual lock holds off the commit
    axi_write(32'h14, 32'h0000_BEEF, 4'hF, r);
    axi_write(32'h1C, 32'h0000_5A5A, 4'h1, r);
    axi_read(32'h1C, d, r); chk("rd_shadow2_bytes", 64'(d), 64'h005A);
    axi_write(32'h08, 32'h1, 4'hF, r);
    chk("lock_set", 64'(man_lock), 64'd1);
    axi_write(32'h0C, 32'h1, 4'hF, r);
    sof_pulse();
    sof_pulse();
    chk("coef_held_locked", 64'(man_coef), 64'h0000_1234_0000);
    axi_read(32'h10, d, r); chk("pending_while_locked", 64'(d), 64'd1);
    axi_write(32'h08, 32'h0, 4'hF, r);
    chk("coef_held_unlock", 64'(man_coef), 64'h0000_1234_0000);
    sof_pulse();
    chk("coef_applied_unlock", 64'(man_coef), 64'h005A_1234_BEEF);
    axi_read(32'h10, d, r); chk("status_cleared2", 64'(d), 64'd0);
    axi_write(32'h14, 32'h0000_1111, 4'hF, r);
    sof_pulse();
    chk("sof_no_pending", 64'(man_coef), 64'h005A_1234_BEEF);

    // 6: back-to-back calibration strobes
    mon_en = 1'b1;
    axi_write(32'h04, 32'h1, 4'hF, r);
    axi_write(32'h04, 32'h1, 4'hF, r);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("cal_pulses", 64'(cal_rises), 64'd2);
    chk("cal_high_cycles", 64'(cal_highs), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
